// File: rtl/disp_arbiter.sv
// disp_arbiter: two-source display arbiter with a tick-based minimum hold time.
//
// Source A (live time) and source B (lap/message overlay) each present four BCD
// digits and a decimal-point request. A three-state FSM (idle, grant A, grant B)
// picks which source reaches the display serializer. B wins ties from idle. Once a
// grant is made it is kept for at least HOLD prescaler ticks before the other
// requester can take over. Under constant contention this gives round-robin
// alternation.
//
// Optional feature: define DISP_BLINK_EN to make the B display blink. It then
// alternates between visible and blank every BLINK_TICKS ticks. When the macro is
// undefined, B is shown steadily and BLINK_TICKS has no effect.
//
// Parameters:
//   DIV          clocks per tick, 1..65535 (16-bit prescaler)
//   HOLD         minimum ticks a grant is kept, 0..255 (8-bit counter)
//   BLINK_TICKS  ticks per blink phase, 1..255 (DISP_BLINK_EN only)
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   req_a, req_b        level requests from source A / source B
//   dig_a, dig_b        four BCD nibbles per source, [15:12] leftmost
//   pt_a, pt_b          decimal-point request per source
//   digit1..digit4      selected digits (digit1 = [15:12]); 4'hF when blank
//   ptflag              selected decimal point
//   gnt_a, gnt_b        registered one-hot grants
//   busy                gnt_a | gnt_b
module disp_arbiter #(
  parameter int unsigned DIV         = 4,
  parameter int unsigned HOLD        = 3,
  parameter int unsigned BLINK_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] dig_a,
  input  logic [15:0] dig_b,
  input  logic        pt_a,
  input  logic        pt_b,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic        ptflag,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

  localparam logic [15:0] PreLast  = 16'(DIV - 1);
  localparam logic [7:0]  HoldInit = 8'(HOLD);
  localparam logic [15:0] Blank    = 16'hFFFF;

  state_e      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] digits_q, digits_d;
  logic        pt_q, pt_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        tick;
  logic        grant_entry;

  // Free-running prescaler.
  assign tick = (pre_q == PreLast);

  always_comb begin
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
  end

  // Arbitration FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_b) begin
          state_d = StGrantB;
        end else if (req_a) begin
          state_d = StGrantA;
        end
      end
      StGrantA: begin
        if (!req_a) begin
          state_d = StIdle;
        end else if ((hold_q == 8'd0) && req_b) begin
          state_d = StGrantB;
        end
      end
      StGrantB: begin
        if (!req_b) begin
          state_d = StIdle;
        end else if ((hold_q == 8'd0) && req_a) begin
          state_d = StGrantA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant_entry = (state_d != state_q) && (state_d != StIdle);

  // A fresh grant reloads the hold counter. The reload takes precedence over a
  // tick that lands on the same edge.
  always_comb begin
    hold_d = hold_q;
    if (grant_entry) begin
      hold_d = HoldInit;
    end else if (tick && (hold_q != 8'd0)) begin
      hold_d = hold_q - 8'd1;
    end
  end

`ifdef DISP_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;

  localparam logic [7:0] BlinkLast = 8'(BLINK_TICKS - 1);

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if ((state_d == StGrantB) && (state_q != StGrantB)) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b0;
    end else if ((state_q == StGrantB) && tick) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  logic unused_blink_ticks;
  assign unused_blink_ticks = ^BLINK_TICKS;
`endif

  // Outputs decode the next state, so they change on the same edge as the state.
  always_comb begin
    gnt_a_d  = (state_d == StGrantA);
    gnt_b_d  = (state_d == StGrantB);
    digits_d = Blank;
    pt_d     = 1'b0;
    unique case (state_d)
      StGrantA: begin
        digits_d = dig_a;
        pt_d     = pt_a;
      end
      StGrantB: begin
        digits_d = dig_b;
        pt_d     = pt_b;
`ifdef DISP_BLINK_EN
        if (phase_d) begin
          digits_d = Blank;
          pt_d     = 1'b0;
        end
`endif
      end
      default: begin
        digits_d = Blank;
        pt_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pre_q    <= 16'd0;
      hold_q   <= 8'd0;
      digits_q <= Blank;
      pt_q     <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      hold_q   <= hold_d;
      digits_q <= digits_d;
      pt_q     <= pt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
    end
  end

  assign digit1 = digits_q[15:12];
  assign digit2 = digits_q[11:8];
  assign digit3 = digits_q[7:4];
  assign digit4 = digits_q[3:0];
  assign ptflag = pt_q;
  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign busy   = gnt_a_q | gnt_b_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed testbench for disp_arbiter (DIV=4, HOLD=3, BLINK_TICKS=2).
// Inputs change and outputs are sampled 1 ns after a rising edge.
module tb_disp_arbiter;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic        req_b;
  logic [15:0] dig_a;
  logic [15:0] dig_b;
  logic        pt_a;
  logic        pt_b;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic [3:0]  digit4;
  logic        ptflag;
  logic        gnt_a;
  logic        gnt_b;
  logic        busy;

  int total;
  int bad;

  disp_arbiter #(
    .DIV        (4),
    .HOLD       (3),
    .BLINK_TICKS(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .dig_a (dig_a),
    .dig_b (dig_b),
    .pt_a  (pt_a),
    .pt_b  (pt_b),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .digit4(digit4),
    .ptflag(ptflag),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic ea, input logic eb);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {gnt_a, gnt_b, busy};
    exp = {ea, eb, ea | eb};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: gnt_a/gnt_b/busy observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic ept, input logic [15:0] ed);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {ptflag, digit1, digit2, digit3, digit4};
    exp = {ept, ed};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: ptflag/digits observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic vis;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    dig_a = 16'h1234;
    pt_a  = 1'b1;
    dig_b = 16'h5678;
    pt_b  = 1'b0;

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    chk_gnt("rst_async_gnt", 1'b0, 1'b0);
    chk_disp("rst_async_disp", 1'b0, 16'hFFFF);
    clk_n(1);
    chk_disp("rst_held_disp", 1'b0, 16'hFFFF);

    // Release; edge n after release leaves the prescaler at n mod 4.
    rst   = 1'b0;
    req_a = 1'b1;
    clk_n(1);  // edge 1: enter A
    chk_gnt("a_grant", 1'b1, 1'b0);
    chk_disp("a_digits", 1'b1, 16'h1234);

    req_b = 1'b1;
    dig_a = 16'h9ABC;
    clk_n(1);  // edge 2
    chk_gnt("a_hold", 1'b1, 1'b0);
    chk_disp("a_track", 1'b1, 16'h9ABC);

    // Ticks at edges 4, 8, 12 run the hold counter out.
    clk_n(10);  // edge 12
    chk_gnt("a_hold_end", 1'b1, 1'b0);
    clk_n(1);  // edge 13
    chk_gnt("rr_to_b", 1'b0, 1'b1);
    chk_disp("b_digits", 1'b0, 16'h5678);

    clk_n(11);  // edge 24
    chk_gnt("b_hold_end", 1'b0, 1'b1);
    clk_n(1);  // edge 25
    chk_gnt("rr_to_a", 1'b1, 1'b0);
    chk_disp("a_again", 1'b1, 16'h9ABC);

    clk_n(12);  // edge 37
    chk_gnt("rr_to_b2", 1'b0, 1'b1);
    clk_n(4);  // edge 41: hold is 2
    chk_disp("b_hold2", 1'b0, 16'h5678);

    req_a = 1'b0;
    req_b = 1'b0;
    clk_n(1);  // edge 42
    chk_gnt("b_drop_idle", 1'b0, 1'b0);
    chk_disp("idle_blank", 1'b0, 16'hFFFF);

    // Simultaneous requests from idle go to B.
    req_a = 1'b1;
    req_b = 1'b1;
    clk_n(1);  // edge 43
    chk_gnt("simul_b", 1'b0, 1'b1);
    chk_disp("simul_b_disp", 1'b0, 16'h5678);

    // Reset pulse mid-cycle while B is granted.
    #3 rst = 1'b1;
    #1;
    chk_gnt("rst_mid_gnt", 1'b0, 1'b0);
    chk_disp("rst_mid_disp", 1'b0, 16'hFFFF);
    #1 rst = 1'b0;
    req_b = 1'b0;
    clk_n(1);  // edge 1'
    chk_gnt("post_rst_a", 1'b1, 1'b0);
    chk_disp("post_rst_disp", 1'b1, 16'h9ABC);

    req_a = 1'b0;
    clk_n(1);  // edge 2'
    chk_gnt("a_drop_idle", 1'b0, 1'b0);
    clk_n(1);  // edge 3'
    chk_gnt("idle_stay", 1'b0, 1'b0);
    chk_disp("idle_stay_disp", 1'b0, 16'hFFFF);

    // B entry on edge 4', where the prescaler wraps.
    req_b = 1'b1;
    pt_b  = 1'b1;
    clk_n(1);  // edge 4'
    chk_gnt("b_blink_entry", 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
`ifdef DISP_BLINK_EN
      vis = (i < 8);
`else
      vis = 1'b1;
`endif
      chk_disp($sformatf("b_phase_%0d", i), vis, vis ? 16'h5678 : 16'hFFFF);
      clk_n(1);
    end
    chk_disp("b_phase_wrap", 1'b1, 16'h5678);
    chk_gnt("b_steady_gnt", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
